// File: rtl/module_spi_ctrl_if.sv
// Requester-side bus of the SPI transaction controller.
// The master modport is the requester pair; the slave modport is the controller.
interface module_spi_ctrl_if #(
    parameter int unsigned MAX_BYTES = 4
) ();
    logic [1:0]             req_i;
    logic [2:0]             len0_i;
    logic [2:0]             len1_i;
    logic [8*MAX_BYTES-1:0] tx0_data_i;
    logic [8*MAX_BYTES-1:0] tx1_data_i;
    logic [1:0]             gnt_o;
    logic [1:0]             done_o;
    logic [8*MAX_BYTES-1:0] rx_data_o;
    logic                   busy_o;

    modport master (
        output req_i, len0_i, len1_i, tx0_data_i, tx1_data_i,
        input  gnt_o, done_o, rx_data_o, busy_o
    );

    modport slave (
        input  req_i, len0_i, len1_i, tx0_data_i, tx1_data_i,
        output gnt_o, done_o, rx_data_o, busy_o
    );
endinterface

// File: rtl/module_spi_ctrl.sv
// SPI transaction controller: round-robin arbitration between two requesters,
// chip-select framing, byte-at-a-time feeding of the SPI byte engine and
// collection of the received bytes. All outputs are registered.
module module_spi_ctrl #(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned CS_SETUP  = 50,
    parameter int unsigned CS_HOLD   = 50,
    parameter int unsigned GAP       = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    module_spi_ctrl_if.slave bus,
    output logic             cs_n_o,
    output logic             spi_en_o,
    output logic [7:0]       spi_data_o,
    input  logic             spi_fin_i,
    input  logic [7:0]       spi_rx_i
);
    localparam int unsigned W = 8 * MAX_BYTES;
    localparam logic [W-1:0] ByteMask = W'(8'hFF);

    typedef enum logic [2:0] {StIdle, StSetup, StXfer, StGap, StHold, StDone} state_e;

    state_e       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [2:0]   k_q, k_d;
    logic [2:0]   len_q, len_d;
    logic [W-1:0] tx_q, tx_d;
    logic [W-1:0] rx_q, rx_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [1:0]   done_q, done_d;
    logic         busy_q, busy_d;
    logic         cs_n_q, cs_n_d;
    logic         en_q, en_d;
    logic [7:0]   data_q, data_d;
    logic         last_q, last_d;  // requester granted most recently

    logic         sel;             // requester that would be granted now
    logic [2:0]   raw_len;
    logic [2:0]   eff_len;
    logic [7:0]   cur_byte;
    logic [31:0]  cnt_tgt;
    logic [15:0]  cnt_inc;
    logic [2:0]   shift_k;

    // Round-robin choice and length clamp for the candidate requester
    always_comb begin
        sel     = (bus.req_i == 2'b11) ? ~last_q : bus.req_i[1];
        raw_len = sel ? bus.len1_i : bus.len0_i;
        if (raw_len == 3'd0) begin
            eff_len = 3'd1;
        end else if (32'(raw_len) > MAX_BYTES) begin
            eff_len = 3'(MAX_BYTES);
        end else begin
            eff_len = raw_len;
        end
    end

    // Wait counter target of the current state; the counter saturates there
    always_comb begin
        case (state_q)
            StSetup: cnt_tgt = CS_SETUP;
            StGap:   cnt_tgt = GAP;
            StHold:  cnt_tgt = CS_HOLD;
            default: cnt_tgt = 32'd0;
        endcase
        cnt_inc  = (32'(cnt_q) >= cnt_tgt) ? cnt_q : cnt_q + 16'd1;
        shift_k  = k_q;
        cur_byte = 8'(tx_q >> {shift_k, 3'b000});
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        len_d   = len_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        busy_d  = busy_q;
        cs_n_d  = cs_n_q;
        en_d    = en_q;
        data_d  = data_q;
        last_d  = last_q;

        unique case (state_q)
            StIdle: begin
                if (|bus.req_i) begin
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    tx_d    = sel ? bus.tx1_data_i : bus.tx0_data_i;
                    len_d   = eff_len;
                    rx_d    = '0;
                    k_d     = 3'd0;
                    cnt_d   = 16'd0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                // The grant edge already counts as the first setup cycle
                if (32'(cnt_q) + 32'd1 >= CS_SETUP) begin
                    en_d    = 1'b1;
                    data_d  = cur_byte;
                    cnt_d   = 16'd0;
                    state_d = StXfer;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StXfer: begin
                if (spi_fin_i) begin
                    // Drop en on the fin edge so the engine does not restart
                    en_d  = 1'b0;
                    rx_d  = (rx_q & ~(ByteMask << {k_q, 3'b000}))
                          | (W'(spi_rx_i) << {k_q, 3'b000});
                    cnt_d = 16'd0;
                    if (k_q == len_q - 3'd1) begin
                        state_d = StHold;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (32'(cnt_q) >= GAP) begin
                    en_d    = 1'b1;
                    data_d  = cur_byte;
                    cnt_d   = 16'd0;
                    state_d = StXfer;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StHold: begin
                if (32'(cnt_q) >= CS_HOLD) begin
                    cs_n_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                done_d  = gnt_q;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                last_d  = gnt_q[1];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any transaction at once
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            k_q     <= 3'd0;
            len_q   <= 3'd0;
            tx_q    <= '0;
            rx_q    <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            en_q    <= 1'b0;
            data_q  <= 8'd0;
            last_q  <= 1'b1;  // so requester 0 wins the first tie
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            len_q   <= len_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            en_q    <= en_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.done_o    = done_q;
    assign bus.rx_data_o = rx_q;
    assign bus.busy_o    = busy_q;
    assign cs_n_o        = cs_n_q;
    assign spi_en_o      = en_q;
    assign spi_data_o    = data_q;
endmodule
